// File: rtl/cve2_instr_aligner.sv
// cve2_instr_aligner: turns 4-byte-aligned fetch words into one instruction per
// handshake (32-bit or zero-extended 16-bit compressed), tracking PC, buffering
// the leftover upper halfword, joining straddling 32-bit instructions and
// handling halfword-aligned redirects.
// Optional performance counters are enabled with the macro CVE2_ALIGNER_PERF_EN.
//
//   state    | meaning
//   ---------+---------------------------------------------------------------
//   ALIGNED  | no residual halfword, pc_q points at the low half of a word
//   RESIDUAL | res_q holds the halfword at pc_q (upper half of a consumed word)
//   SKIP_LOW | after redirect to a halfword target, drop low half of next word
module cve2_instr_aligner #(
  parameter logic [31:0] BOOT_ADDR = 32'h0000_0080
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        fetch_valid_i,
  output logic        fetch_ready_o,
  input  logic [31:0] fetch_rdata_i,
  input  logic        fetch_err_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_addr_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_instr_o,
  output logic [31:0] out_pc_o,
  output logic        out_is_compressed_o,
  output logic        out_err_o,
  output logic [31:0] perf_cnt_c_o,
  output logic [31:0] perf_cnt_stall_o
);

  typedef enum logic [1:0] {ALIGNED, RESIDUAL, SKIP_LOW} state_e;

  state_e      st_q, st_d;
  logic [15:0] res_q, res_d;
  logic        res_err_q, res_err_d;
  logic [31:0] pc_q, pc_d;

  assign out_pc_o            = pc_q;
  assign out_is_compressed_o = (out_instr_o[1:0] != 2'b11);

  // Output decode and next-state; redirect overrides everything, reset masks handshakes.
  always_comb begin
    out_valid_o   = 1'b0;
    fetch_ready_o = 1'b0;
    out_instr_o   = {16'h0, fetch_rdata_i[15:0]};
    out_err_o     = fetch_err_i;
    st_d          = st_q;
    res_d         = res_q;
    res_err_d     = res_err_q;
    pc_d          = pc_q;

    case (st_q)
      ALIGNED: begin
        out_valid_o   = fetch_valid_i;
        fetch_ready_o = out_ready_i;
        if (fetch_rdata_i[1:0] == 2'b11) begin
          out_instr_o = fetch_rdata_i;
          if (fetch_valid_i && out_ready_i) pc_d = pc_q + 32'd4;
        end else if (fetch_valid_i && out_ready_i) begin
          res_d     = fetch_rdata_i[31:16];
          res_err_d = fetch_err_i;
          pc_d      = pc_q + 32'd2;
          st_d      = RESIDUAL;
        end
      end
      RESIDUAL: begin
        if (res_q[1:0] != 2'b11) begin
          // Buffered compressed instruction needs no new fetch word.
          out_valid_o = 1'b1;
          out_instr_o = {16'h0, res_q};
          out_err_o   = res_err_q;
          if (out_ready_i) begin
            pc_d = pc_q + 32'd2;
            st_d = ALIGNED;
          end
        end else begin
          out_valid_o   = fetch_valid_i;
          out_instr_o   = {fetch_rdata_i[15:0], res_q};
          out_err_o     = res_err_q | fetch_err_i;
          fetch_ready_o = out_ready_i;
          if (fetch_valid_i && out_ready_i) begin
            res_d     = fetch_rdata_i[31:16];
            res_err_d = fetch_err_i;
            pc_d      = pc_q + 32'd4;
          end
        end
      end
      SKIP_LOW: begin
        fetch_ready_o = 1'b1;
        if (fetch_valid_i) begin
          res_d     = fetch_rdata_i[31:16];
          res_err_d = fetch_err_i;
          st_d      = RESIDUAL;
        end
      end
      default: st_d = ALIGNED;
    endcase

    if (redirect_i) begin
      out_valid_o   = 1'b0;
      fetch_ready_o = 1'b1;
      pc_d          = {redirect_addr_i[31:1], 1'b0};
      res_d         = 16'h0;
      res_err_d     = 1'b0;
      st_d          = redirect_addr_i[1] ? SKIP_LOW : ALIGNED;
    end

    if (rst_i) begin
      out_valid_o   = 1'b0;
      fetch_ready_o = 1'b0;
    end
  end

  // State, residual halfword and PC registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      st_q      <= ALIGNED;
      res_q     <= 16'h0;
      res_err_q <= 1'b0;
      pc_q      <= {BOOT_ADDR[31:1], 1'b0};
    end else begin
      st_q      <= st_d;
      res_q     <= res_d;
      res_err_q <= res_err_d;
      pc_q      <= pc_d;
    end
  end

`ifdef CVE2_ALIGNER_PERF_EN
  logic [31:0] cnt_c_q, cnt_stall_q;

  // Performance counters survive redirects; only reset clears them.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_c_q     <= 32'h0;
      cnt_stall_q <= 32'h0;
    end else begin
      if (out_valid_o && out_ready_i && out_is_compressed_o) cnt_c_q <= cnt_c_q + 32'd1;
      if (out_valid_o && !out_ready_i) cnt_stall_q <= cnt_stall_q + 32'd1;
    end
  end

  assign perf_cnt_c_o     = cnt_c_q;
  assign perf_cnt_stall_o = cnt_stall_q;
`else
  assign perf_cnt_c_o     = 32'h0;
  assign perf_cnt_stall_o = 32'h0;
`endif

endmodule

// File: doc/cve2_instr_aligner.md
Name: cve2_instr_aligner

Overview:
- Sits between the fetch FIFO and the compressed/regular decoder.
- Turns a stream of 4-byte-aligned 32-bit fetch words into one instruction per handshake: a 32-bit instruction, or a compressed 16-bit instruction zero-extended to 32 bits.
- Tracks the PC, buffers the leftover upper halfword, joins 32-bit instructions that straddle two fetch words, and handles redirects to halfword-aligned targets.

Parameters:
- BOOT_ADDR, 32'h0000_0080, PC loaded at reset. Bit 0 is ignored. Bit 1 must be 0.

Ports:
- clk_i  in  1  clock, rising-edge.
- rst_i  in  1  reset, asynchronous, active-high.
- fetch_valid_i  in  1  fetch word valid.
- fetch_ready_o  out  1  aligner consumes the fetch word this cycle.
- fetch_rdata_i  in  32  fetch word, 4-byte aligned.
- fetch_err_i  in  1  bus error on this fetch word.
- redirect_i  in  1  branch/exception redirect; highest priority.
- redirect_addr_i  in  32  redirect target. Bit 0 is ignored.
- out_valid_o  out  1  instruction valid.
- out_ready_i  in  1  decoder accepts.
- out_instr_o  out  32  raw instruction, compressed = {16'h0, hw}.
- out_pc_o  out  32  PC of out_instr_o.
- out_is_compressed_o  out  1  out_instr_o[1:0] != 2'b11.
- out_err_o  out  1  some part of the instruction came from an erroring word.
- perf_cnt_c_o  out  32  accepted compressed-instruction count (optional feature).
- perf_cnt_stall_o  out  32  cycles with out_valid_o=1 and out_ready_i=0 (optional feature).

Behaviour:
- State register st_q ∈ {ALIGNED, RESIDUAL, SKIP_LOW}. Also held: res_q[15:0], res_err_q, pc_q[31:0].
- Reset values: st_q=ALIGNED, res_q=0, res_err_q=0, pc_q=BOOT_ADDR. While rst_i=1: out_valid_o=0, fetch_ready_o=0, all counters 0.
- Output handshake ("hs") = out_valid_o & out_ready_i.
- out_pc_o = pc_q. Outputs are combinational from state and fetch inputs; zero added latency.
- ALIGNED (no residual, pc_q[1]=0):
  - Case fetch_rdata_i[1:0]==11: out_valid_o=fetch_valid_i, out_instr_o=fetch_rdata_i, out_err_o=fetch_err_i, fetch_ready_o=out_ready_i. On hs: pc_q+=4, stay.
  - Otherwise: out_instr_o={16'h0, fetch_rdata_i[15:0]}. On hs: res_q=fetch_rdata_i[31:16], res_err_q=fetch_err_i, fetch_ready_o=1, pc_q+=2, go RESIDUAL.
- RESIDUAL (res_q holds the halfword at pc_q, pc_q[1]=1):
  - Case res_q[1:0]!=11: out_valid_o=1 without needing a fetch word, out_instr_o={16'h0, res_q}, out_err_o=res_err_q, fetch_ready_o=0. On hs: pc_q+=2, go ALIGNED.
  - Otherwise (straddle): out_valid_o=fetch_valid_i, out_instr_o={fetch_rdata_i[15:0], res_q}, out_err_o=res_err_q|fetch_err_i, fetch_ready_o=out_ready_i. On hs: res_q=fetch_rdata_i[31:16], res_err_q=fetch_err_i, pc_q+=4, stay RESIDUAL.
- SKIP_LOW (after a redirect with target bit 1 set):
  - out_valid_o=0, fetch_ready_o=1.
  - On fetch_valid_i: res_q=fetch_rdata_i[31:16], res_err_q=fetch_err_i, go RESIDUAL. Low halfword is dropped. One-cycle bubble.
- Redirect (any state, overrides everything above):
  - out_valid_o=0 and fetch_ready_o=1 that cycle; any presented fetch word is discarded.
  - Next: pc_q={redirect_addr_i[31:1],1'b0}, res_q and res_err_q cleared, st_q = redirect_addr_i[1] ? SKIP_LOW : ALIGNED.
- PC arithmetic is modulo 2^32; 32'hFFFF_FFFE+2 wraps to 0.
- Output stability: once out_valid_o=1 with out_ready_i=0, out_instr_o/out_pc_o stay stable as long as fetch inputs are held stable. Fetch-side rule: fetch_valid_i must not drop while not consumed.
- out_is_compressed_o = out_instr_o[1:0] != 2'b11, including when out_err_o=1.

Optional Feature:
- Macro: CVE2_ALIGNER_PERF_EN.
- Defined: perf_cnt_c_o increments on each hs with out_is_compressed_o=1. perf_cnt_stall_o increments each cycle with out_valid_o & ~out_ready_i. Both are 32-bit, wrap at 2^32, and are cleared on reset and not on redirect.
- Undefined: both ports are tied to 32'h0 and no counter flops exist.

Test Plan:
- Reset, BOOT_ADDR=0x80, word 0x00A00093 (addi) -> out_instr_o=0x00A00093, pc 0x80, is_compressed=0, then pc_q=0x84.
- Word 0x45014505 -> two outputs: 0x00004505 @0x80, then 0x00004501 @0x82 with fetch_ready_o=0 on the second; final pc 0x84.
- Straddle: word 0x00934505, then 0x4501_00A0 -> 0x00004505 @0x80, then 0x00A00093 @0x82 (err=0), and res_q=0x4501.
- Redirect to 0x102, next word 0x4505_1234 -> low half dropped, bubble cycle, output 0x00004505 @0x102.
- Straddle with fetch_err_i=1 on the second word -> out_err_o=1; res_err_q=1 carried into the next halfword's output.
- Back-pressure out_ready_i=0 for 5 cycles with PERF_EN -> outputs stable, perf_cnt_stall_o=5; redirect mid-stall -> out_valid_o=0 and new pc taken next cycle.
